rct_inverse: RTL and testbench
==============================

// Module: rct_inverse
// PURPOSE
//  Inverse reversible colour transform (JPEG2000 RCT) stage. It converts two pixels per cycle from (Y,U,V) to 8-bit RGB.
//  Sits directly upstream of the display panel model and drives its RECON_VALID / DATA_RECON_{R,G,B}{0,1} inputs.
//  Fixed 2-cycle pipeline with no backpressure, a per-frame pair counter and a sticky range-error flag.
// PARAMETERS
//  WIDTH   768  image width in pixels (even)
//  HEIGHT  512  image height in lines
// PORTS
//  HCLK            in   1  clock, rising edge
//  HRESETn         in   1  asynchronous active-low reset
//  RCT_VALID       in   1  input pixel pair valid this cycle
//  RCT_Y0, RCT_Y1  in   8  luma, unsigned 0..255
//  RCT_U0, RCT_U1  in   9  U = B-G, two's complement -255..255
//  RCT_V0, RCT_V1  in   9  V = R-G, two's complement -255..255
//  RECON_VALID     out  1  output pixel pair valid
//  DATA_RECON_R0/G0/B0  out 8  pixel 0 (left pixel of pair)
//  DATA_RECON_R1/G1/B1  out 8  pixel 1 (right pixel of pair)
//  FRAME_DONE      out  1  1-cycle pulse coincident with last pair of frame
//  RANGE_ERR       out  1  sticky: some computed R/G/B left 0..255
// BEHAVIOUR
//  - Reset: all outputs 0; pipeline valid bits 0; pair counter 0; RANGE_ERR 0.
//  - Per pixel: t = (U+V) >>> 2 (10-bit signed sum, arithmetic shift = floor); G = Y - t; R = V + G; B = U + G.
//    Internal width is 11-bit signed, so no intermediate overflows.
//  - Stage 1 (cycle n+1): register G, U, V and valid for both pixels.
//  - Stage 2 (cycle n+2): register R, G, B (range-limited) and RECON_VALID.
//  - Latency: exactly 2 HCLK from RCT_VALID to RECON_VALID.
//  - Throughput: one pair per cycle. Gaps in RCT_VALID propagate as gaps in RECON_VALID.
//  - Data outputs hold their last value while RECON_VALID = 0.
//  - Range check: if any of the 6 computed values is <0 or >255 in a valid pair, set RANGE_ERR at stage 2.
//    RANGE_ERR clears only on reset.
//  - Pair counter increments on each RECON_VALID, range 0..WIDTH*HEIGHT/2-1 (196607 with defaults).
//  - FRAME_DONE = RECON_VALID && count == WIDTH*HEIGHT/2-1, registered with the stage-2 outputs.
//    On that pair the counter wraps to 0, and the next frame starts immediately with no dead cycle.
//  - Reset asserted mid-frame: in-flight pairs are discarded, the counter returns to 0, and no FRAME_DONE is emitted.
//  - Invalid input cycles do not advance the counter and do not affect RANGE_ERR.
// CONFIGURATION
//  RCT_CLAMP_EN defined: out-of-range values saturate (<0 -> 0, >255 -> 255).
//  RCT_CLAMP_EN undefined: outputs are the low 8 bits of the result (wrap).
//  RANGE_ERR behaviour is identical in both builds.
// STRUCTURE
//  - Package rct_pkg holds:
//    - localparams PIX_W=8, CHR_W=9, INT_W=11;
//    - typedef rct_yuv_t {Y,U,V} and rct_rgb_t {R,G,B};
//    - function rct_lim() implementing clamp/wrap per RCT_CLAMP_EN.
//  - Sub-module rct_pix_inv: combinational per-pixel inverse transform plus out-of-range flag.
//    rct_inverse instantiates it twice (pixel 0, pixel 1).
//  - rct_inverse owns the pipeline registers, counter and flags.
// TESTING
//  1 R200/G100/B50 pair: Y=112,U=-50,V=100 -> after 2 cycles R=200,G=100,B=50 for both pixels, RANGE_ERR=0.
//  2 Floor check: Y=127,U=-255,V=-255 -> t=-128, G=255, R=0, B=0; Y=0,U=0,V=0 -> RGB 0,0,0.
//  3 Range: Y=255,U=255,V=255 -> G=128, R=B=383.
//    With RCT_CLAMP_EN: R=B=255. Without: R=B=127. Both builds: RANGE_ERR=1 and it stays 1.
//  4 Frame: 196608 back-to-back valid pairs -> FRAME_DONE high only with pair 196608.
//    The next pair counts as 0, and a second frame pulses again after 196608 more pairs.
//  5 Gaps: RCT_VALID pattern 1,0,1,1,0 -> RECON_VALID pattern 0,0,1,0,1,1,0.
//    Data held during gaps; the counter advances by 3.
//  6 Reset: drop HRESETn after 1000 pairs with 2 pairs in flight -> outputs 0 immediately.
//    Counter 0, no RECON_VALID for the discarded pairs; a full frame then gives FRAME_DONE after 196608 pairs.

Source files
------------

// File: rtl/rct_pkg.sv
// Shared widths, pixel types and the output range limiter for the inverse RCT.
// Latency: none (types and pure functions). Backpressure: not applicable.
// Build option RCT_CLAMP_EN: saturate out-of-range results instead of keeping the low 8 bits.
package rct_pkg;

    localparam int PIX_W = 8;
    localparam int CHR_W = 9;
    localparam int INT_W = 11;

    // U and V are carried as raw two's complement bit patterns.
    typedef struct packed {
        logic [PIX_W-1:0] y;
        logic [CHR_W-1:0] u;
        logic [CHR_W-1:0] v;
    } rct_yuv_t;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rct_rgb_t;

    function automatic logic [PIX_W-1:0] rct_lim(input logic signed [INT_W-1:0] x);
`ifdef RCT_CLAMP_EN
        if (x < 11'sd0) begin
            return '0;
        end else if (x > 11'sd255) begin
            return '1;
        end else begin
            return x[PIX_W-1:0];
        end
`else
        return x[PIX_W-1:0];
`endif
    endfunction

    function automatic logic rct_oor(input logic signed [INT_W-1:0] x);
        return (x < 11'sd0) || (x > 11'sd255);
    endfunction

endpackage

// File: rtl/rct_inverse_if.sv
// Pixel-pair bus: YUV pair in, reconstructed RGB pair plus frame/error status out.
// Latency: none (wires only). Backpressure: none, the stream is valid-only.
interface rct_inverse_if;
    import rct_pkg::*;

    logic             RCT_VALID;
    logic [PIX_W-1:0] RCT_Y0;
    logic [PIX_W-1:0] RCT_Y1;
    logic [CHR_W-1:0] RCT_U0;
    logic [CHR_W-1:0] RCT_U1;
    logic [CHR_W-1:0] RCT_V0;
    logic [CHR_W-1:0] RCT_V1;

    logic             RECON_VALID;
    logic [PIX_W-1:0] DATA_RECON_R0;
    logic [PIX_W-1:0] DATA_RECON_G0;
    logic [PIX_W-1:0] DATA_RECON_B0;
    logic [PIX_W-1:0] DATA_RECON_R1;
    logic [PIX_W-1:0] DATA_RECON_G1;
    logic [PIX_W-1:0] DATA_RECON_B1;
    logic             FRAME_DONE;
    logic             RANGE_ERR;

    modport master (
        output RCT_VALID, RCT_Y0, RCT_Y1, RCT_U0, RCT_U1, RCT_V0, RCT_V1,
        input  RECON_VALID, DATA_RECON_R0, DATA_RECON_G0, DATA_RECON_B0,
        input  DATA_RECON_R1, DATA_RECON_G1, DATA_RECON_B1, FRAME_DONE, RANGE_ERR
    );

    modport slave (
        input  RCT_VALID, RCT_Y0, RCT_Y1, RCT_U0, RCT_U1, RCT_V0, RCT_V1,
        output RECON_VALID, DATA_RECON_R0, DATA_RECON_G0, DATA_RECON_B0,
        output DATA_RECON_R1, DATA_RECON_G1, DATA_RECON_B1, FRAME_DONE, RANGE_ERR
    );

endinterface

// File: rtl/rct_pix_inv.sv
// Per-pixel inverse RCT: G from raw YUV, then R/B/limit/out-of-range from the staged G,U,V.
// Latency: combinational, split across the caller's stage-1 register. Backpressure: none.
module rct_pix_inv
    import rct_pkg::*;
(
    input  rct_yuv_t                yuv,
    output logic signed [INT_W-1:0] g_pre,
    input  logic signed [INT_W-1:0] g_s1,
    input  logic        [CHR_W-1:0] u_s1,
    input  logic        [CHR_W-1:0] v_s1,
    output rct_rgb_t                rgb,
    output logic                    oor
);

    logic signed [CHR_W:0]   uv_sum;
    logic signed [CHR_W:0]   t;
    logic signed [INT_W-1:0] r_full;
    logic signed [INT_W-1:0] b_full;

    // Arithmetic shift gives floor((U+V)/4), also for negative sums.
    assign uv_sum = $signed({yuv.u[CHR_W-1], yuv.u}) + $signed({yuv.v[CHR_W-1], yuv.v});
    assign t      = uv_sum >>> 2;
    assign g_pre  = $signed({{(INT_W-PIX_W){1'b0}}, yuv.y})
                  - $signed({{(INT_W-CHR_W-1){t[CHR_W]}}, t});

    assign r_full = $signed({{(INT_W-CHR_W){v_s1[CHR_W-1]}}, v_s1}) + g_s1;
    assign b_full = $signed({{(INT_W-CHR_W){u_s1[CHR_W-1]}}, u_s1}) + g_s1;

    assign rgb.r = rct_lim(r_full);
    assign rgb.g = rct_lim(g_s1);
    assign rgb.b = rct_lim(b_full);
    assign oor   = rct_oor(r_full) | rct_oor(g_s1) | rct_oor(b_full);

endmodule

// File: rtl/rct_inverse.sv
// Inverse RCT for two pixels per cycle, with per-frame pair counter and sticky range error.
// Latency: fixed 2 HCLK from RCT_VALID to RECON_VALID. Backpressure: none, gaps pass through.
module rct_inverse
    import rct_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic HCLK,
    input  logic HRESETn,
    rct_inverse_if.slave bus
);

    localparam int PAIRS = WIDTH * HEIGHT / 2;
    localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);

    rct_yuv_t                yuv0, yuv1;
    logic signed [INT_W-1:0] g_pre0, g_pre1;
    rct_rgb_t                rgb0, rgb1;
    logic                    oor0, oor1;

    logic                    s1_vld;
    logic signed [INT_W-1:0] s1_g0, s1_g1;
    logic        [CHR_W-1:0] s1_u0, s1_u1, s1_v0, s1_v1;

    logic                    recon_vld;
    rct_rgb_t                recon0, recon1;
    logic                    frame_done;
    logic                    range_err;
    logic        [CNT_W-1:0] pair_cnt;

    assign yuv0 = {bus.RCT_Y0, bus.RCT_U0, bus.RCT_V0};
    assign yuv1 = {bus.RCT_Y1, bus.RCT_U1, bus.RCT_V1};

    rct_pix_inv u_pix0 (
        .yuv   (yuv0),
        .g_pre (g_pre0),
        .g_s1  (s1_g0),
        .u_s1  (s1_u0),
        .v_s1  (s1_v0),
        .rgb   (rgb0),
        .oor   (oor0)
    );

    rct_pix_inv u_pix1 (
        .yuv   (yuv1),
        .g_pre (g_pre1),
        .g_s1  (s1_g1),
        .u_s1  (s1_u1),
        .v_s1  (s1_v1),
        .rgb   (rgb1),
        .oor   (oor1)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s1_vld <= 1'b0;
            s1_g0  <= '0;
            s1_g1  <= '0;
            s1_u0  <= '0;
            s1_u1  <= '0;
            s1_v0  <= '0;
            s1_v1  <= '0;
        end else begin
            s1_vld <= bus.RCT_VALID;
            if (bus.RCT_VALID) begin
                s1_g0 <= g_pre0;
                s1_g1 <= g_pre1;
                s1_u0 <= yuv0.u;
                s1_u1 <= yuv1.u;
                s1_v0 <= yuv0.v;
                s1_v1 <= yuv1.v;
            end
        end
    end

    // Data registers only load on valid pairs so the panel sees held values during gaps.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            recon_vld  <= 1'b0;
            recon0     <= '0;
            recon1     <= '0;
            frame_done <= 1'b0;
            range_err  <= 1'b0;
            pair_cnt   <= '0;
        end else begin
            recon_vld  <= s1_vld;
            frame_done <= s1_vld && (pair_cnt == LAST_PAIR);
            if (s1_vld) begin
                recon0 <= rgb0;
                recon1 <= rgb1;
                if (oor0 || oor1) begin
                    range_err <= 1'b1;
                end
                pair_cnt <= (pair_cnt == LAST_PAIR) ? '0 : pair_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.RECON_VALID   = recon_vld;
    assign bus.DATA_RECON_R0 = recon0.r;
    assign bus.DATA_RECON_G0 = recon0.g;
    assign bus.DATA_RECON_B0 = recon0.b;
    assign bus.DATA_RECON_R1 = recon1.r;
    assign bus.DATA_RECON_G1 = recon1.g;
    assign bus.DATA_RECON_B1 = recon1.b;
    assign bus.FRAME_DONE    = frame_done;
    assign bus.RANGE_ERR     = range_err;

endmodule

// File: tb/tb_rct_inverse.sv
// Bench for rct_inverse on a reduced 8x4 frame: vector table, gaps, frames, mid-frame reset, random mix.
module tb_rct_inverse;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int PAIRS = W * H / 2;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b1;

    rct_inverse_if bus ();

    rct_inverse #(.WIDTH(W), .HEIGHT(H)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit vld;
        int y[2];
        int u[2];
        int v[2];
    } pair_t;

    typedef struct {
        int y, u, v;
        int r, g, b;
        bit err;
    } vec_t;

    int    checks   = 0;
    int    failures = 0;
    pair_t hist[$];
    int    m_r[2], m_g[2], m_b[2];
    bit    m_vld, m_fd, m_err;
    int    m_cnt;
    int    n_vld_seen, n_fd_seen;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int floor4(input int s);
        if (s >= 0) return s / 4;
        return -((-s + 3) / 4);
    endfunction

    function automatic int lim(input int x);
`ifdef RCT_CLAMP_EN
        return (x < 0) ? 0 : ((x > 255) ? 255 : x);
`else
        return ((x % 256) + 256) % 256;
`endif
    endfunction

    function automatic bit oor(input int x);
        return (x < 0) || (x > 255);
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 2; i++) begin
            m_r[i] = 0; m_g[i] = 0; m_b[i] = 0;
        end
        m_vld = 0; m_fd = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_recon_valid"}, int'(bus.RECON_VALID), int'(m_vld));
        chk({tag, "_frame_done"},  int'(bus.FRAME_DONE),  int'(m_fd));
        chk({tag, "_range_err"},   int'(bus.RANGE_ERR),   int'(m_err));
        chk({tag, "_r0"}, int'(bus.DATA_RECON_R0), m_r[0]);
        chk({tag, "_g0"}, int'(bus.DATA_RECON_G0), m_g[0]);
        chk({tag, "_b0"}, int'(bus.DATA_RECON_B0), m_b[0]);
        chk({tag, "_r1"}, int'(bus.DATA_RECON_R1), m_r[1]);
        chk({tag, "_g1"}, int'(bus.DATA_RECON_G1), m_g[1]);
        chk({tag, "_b1"}, int'(bus.DATA_RECON_B1), m_b[1]);
    endtask

    // Apply one pair for one cycle, then compare against the pair applied one cycle earlier.
    task automatic drive(input pair_t p, input string tag);
        pair_t e;
        int    g, r, b;
        bus.RCT_VALID = p.vld;
        bus.RCT_Y0 = 8'(p.y[0]); bus.RCT_U0 = 9'(p.u[0]); bus.RCT_V0 = 9'(p.v[0]);
        bus.RCT_Y1 = 8'(p.y[1]); bus.RCT_U1 = 9'(p.u[1]); bus.RCT_V1 = 9'(p.v[1]);
        hist.push_back(p);
        @(posedge HCLK);
        #1;
        m_vld = 0;
        m_fd  = 0;
        if (hist.size() >= 2) begin
            e = hist[hist.size() - 2];
            if (e.vld) begin
                for (int i = 0; i < 2; i++) begin
                    g = e.y[i] - floor4(e.u[i] + e.v[i]);
                    r = e.v[i] + g;
                    b = e.u[i] + g;
                    if (oor(r) || oor(g) || oor(b)) m_err = 1;
                    m_r[i] = lim(r); m_g[i] = lim(g); m_b[i] = lim(b);
                end
                m_vld = 1;
                m_fd  = (m_cnt == PAIRS - 1);
                m_cnt = (m_cnt + 1) % PAIRS;
            end
        end
        while (hist.size() > 2) void'(hist.pop_front());
        check_outputs(tag);
        if (bus.RECON_VALID) n_vld_seen++;
        if (bus.FRAME_DONE) n_fd_seen++;
    endtask

    function automatic pair_t rand_pair(input bit vld);
        pair_t p;
        p.vld = vld;
        for (int i = 0; i < 2; i++) begin
            p.y[i] = int'($urandom_range(0, 255));
            p.u[i] = int'($urandom_range(0, 510)) - 255;
            p.v[i] = int'($urandom_range(0, 510)) - 255;
        end
        return p;
    endfunction

    function automatic pair_t idle_pair();
        pair_t p;
        p = rand_pair(1'b0);
        return p;
    endfunction

    task automatic do_reset();
        pair_t p;
        p = idle_pair();
        bus.RCT_VALID = 1'b0;
        HRESETn = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        drive(p, "post_reset");
        n_vld_seen = 0;
        n_fd_seen  = 0;
    endtask

    vec_t  tbl[6];
    pair_t p;

    initial begin
        bus.RCT_VALID = 0;
        bus.RCT_Y0 = 0; bus.RCT_U0 = 0; bus.RCT_V0 = 0;
        bus.RCT_Y1 = 0; bus.RCT_U1 = 0; bus.RCT_V1 = 0;
        n_vld_seen = 0;
        n_fd_seen  = 0;
        model_reset();
        #2;

        tbl[0] = '{y: 112, u: -50,  v: 100,  r: 200, g: 100, b: 50,  err: 0};
        tbl[1] = '{y: 127, u: -255, v: -255, r: 0,   g: 255, b: 0,   err: 0};
        tbl[2] = '{y: 0,   u: 0,    v: 0,    r: 0,   g: 0,   b: 0,   err: 0};
        tbl[3] = '{y: 10,  u: -3,   v: 0,    r: 11,  g: 11,  b: 8,   err: 0};
`ifdef RCT_CLAMP_EN
        tbl[4] = '{y: 255, u: 255,  v: 255,  r: 255, g: 128, b: 255, err: 1};
        tbl[5] = '{y: 0,   u: 255,  v: -255, r: 0,   g: 0,   b: 255, err: 1};
`else
        tbl[4] = '{y: 255, u: 255,  v: 255,  r: 127, g: 128, b: 127, err: 1};
        tbl[5] = '{y: 0,   u: 255,  v: -255, r: 1,   g: 0,   b: 255, err: 1};
`endif

        // Fixed vectors: one valid pair after reset, then idle cycles to check hold and stickiness.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            p.vld = 1;
            for (int k = 0; k < 2; k++) begin
                p.y[k] = tbl[i].y; p.u[k] = tbl[i].u; p.v[k] = tbl[i].v;
            end
            drive(p, "tbl_in");
            drive(idle_pair(), "tbl_out");
            chk("tbl_r0", int'(bus.DATA_RECON_R0), tbl[i].r);
            chk("tbl_g0", int'(bus.DATA_RECON_G0), tbl[i].g);
            chk("tbl_b0", int'(bus.DATA_RECON_B0), tbl[i].b);
            chk("tbl_r1", int'(bus.DATA_RECON_R1), tbl[i].r);
            chk("tbl_g1", int'(bus.DATA_RECON_G1), tbl[i].g);
            chk("tbl_b1", int'(bus.DATA_RECON_B1), tbl[i].b);
            chk("tbl_err", int'(bus.RANGE_ERR), int'(tbl[i].err));
            drive(idle_pair(), "tbl_hold");
            drive(idle_pair(), "tbl_hold");
            chk("tbl_hold_r0", int'(bus.DATA_RECON_R0), tbl[i].r);
            chk("tbl_err_sticky", int'(bus.RANGE_ERR), int'(tbl[i].err));
        end

        // Gaps 1,0,1,1,0: three outputs, then the rest of the frame must end on the counted pair.
        do_reset();
        drive(rand_pair(1), "gap");
        drive(rand_pair(0), "gap");
        drive(rand_pair(1), "gap");
        drive(rand_pair(1), "gap");
        drive(rand_pair(0), "gap");
        drive(idle_pair(), "gap");
        drive(idle_pair(), "gap");
        chk("gap_valid_count", n_vld_seen, 3);
        chk("gap_no_frame_done", n_fd_seen, 0);
        for (int i = 0; i < PAIRS - 3; i++) drive(rand_pair(1), "gap_fill");
        drive(idle_pair(), "gap_fill");
        drive(idle_pair(), "gap_fill");
        chk("gap_frame_done_count", n_fd_seen, 1);

        // Two back-to-back frames with no dead cycle.
        do_reset();
        for (int i = 0; i < 2 * PAIRS; i++) drive(rand_pair(1), "frame");
        drive(idle_pair(), "frame");
        drive(idle_pair(), "frame");
        chk("frame_pulse_count", n_fd_seen, 2);
        chk("frame_valid_count", n_vld_seen, 2 * PAIRS);

        // Reset mid-frame with pairs in flight and valid still asserted.
        do_reset();
        for (int i = 0; i < 10; i++) drive(rand_pair(1), "pre_rst");
        bus.RCT_VALID = 1'b1;
        HRESETn = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst");
        chk("midrst_valid_zero", int'(bus.RECON_VALID), 0);
        chk("midrst_r0_zero", int'(bus.DATA_RECON_R0), 0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        drive(idle_pair(), "post_midrst");
        n_vld_seen = 0;
        n_fd_seen  = 0;
        for (int i = 0; i < PAIRS; i++) drive(rand_pair(1), "after_rst");
        drive(idle_pair(), "after_rst");
        drive(idle_pair(), "after_rst");
        chk("after_rst_valid_count", n_vld_seen, PAIRS);
        chk("after_rst_frame_done", n_fd_seen, 1);

        // Random valid/gap mix across several frames.
        do_reset();
        for (int i = 0; i < 300; i++) drive(rand_pair($urandom_range(0, 3) != 0), "rand");
        drive(idle_pair(), "rand");
        drive(idle_pair(), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
